// File: rtl/sha256_host_mem.sv
// Host-side partner of the simplified SHA-256 hasher.
//
// Owns the word memory the hasher reads its message from and writes its
// hash into. Each pass loads NUM_OF_WORDS message words from the host
// stream, pulses start, waits for the hasher to go busy and then done, and
// streams the 8 hash words back to the host.
//
// Ports:
//   clk, reset            single rising-edge clock, synchronous active-high reset
//   ld_valid/ld_ready     host message stream handshake
//   ld_data, ld_last      message word and host end-of-message marker
//   start, done           hasher control (one-cycle start pulse, done = idle)
//   message_addr          constant MSG_BASE for the hasher
//   output_addr           constant OUT_BASE for the hasher
//   mem_we, mem_addr,
//   mem_write_data        hasher memory bus (write side)
//   mem_read_data         hasher memory bus, registered read data
//   out_valid/out_ready   hash word stream handshake
//   out_data, out_last    hash word and 8th-word marker
//   busy                  high in every state except LOAD
//   hash_count            completed passes, wraps at 0xFFFF
//   err                   sticky: [0] write collision, [1] address out of
//                         range, [2] length mismatch
module sha256_host_mem #(
    parameter int NUM_OF_WORDS = 20,
    parameter int DEPTH        = 64,
    parameter int MSG_BASE     = 0,
    parameter int OUT_BASE     = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [31:0] ld_data,
    input  logic        ld_last,
    output logic        start,
    input  logic        done,
    output logic [15:0] message_addr,
    output logic [15:0] output_addr,
    input  logic        mem_we,
    input  logic [15:0] mem_addr,
    input  logic [31:0] mem_write_data,
    output logic [31:0] mem_read_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        busy,
    output logic [15:0] hash_count,
    output logic [2:0]  err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(NUM_OF_WORDS + 1);
    localparam logic [CW-1:0] LAST_CNT   = CW'(NUM_OF_WORDS - 1);
    localparam logic [AW-1:0] MSG_BASE_A = AW'(MSG_BASE);
    localparam logic [AW-1:0] OUT_BASE_A = AW'(OUT_BASE);
    localparam logic [16:0]   DEPTH_L    = 17'(DEPTH);

    if (MSG_BASE + NUM_OF_WORDS > OUT_BASE || OUT_BASE + 8 > DEPTH ||
        DEPTH > 65536 || (1 << AW) != DEPTH) begin : g_bad_params
        $fatal(1, "sha256_host_mem: illegal memory layout parameters");
    end

    typedef enum logic [2:0] {
        S_LOAD,
        S_KICK,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_DRAIN
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   mem [DEPTH];
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [2:0]    fetch_idx;
    logic [AW-1:0] load_addr;
    logic [AW-1:0] drain_addr;
    logic          accept;
    logic          addr_ok;
    logic          drain_hs;
    logic          drain_fetch;

    assign message_addr = 16'(MSG_BASE);
    assign output_addr  = 16'(OUT_BASE);

    // NOTE: every signal driven from an always_comb gets a default first,
    // so no path through the case leaves it unassigned and infers a latch.
    always_comb begin
        accept      = ld_valid && ld_ready && !reset;
        addr_ok     = {1'b0, mem_addr} < DEPTH_L;
        drain_hs    = (state_q == S_DRAIN) && out_valid && out_ready;
        // Fetch on the DRAIN entry cycle, and on every handshake except word 7.
        drain_fetch = (state_q == S_DRAIN) &&
                      (!out_valid || (out_ready && idx != 3'd7));
        fetch_idx   = out_valid ? idx + 3'd1 : idx;
        load_addr   = MSG_BASE_A + AW'(cnt);
        drain_addr  = OUT_BASE_A + AW'(fetch_idx);
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        busy    = (state_q != S_LOAD);
        case (state_q)
            S_LOAD:      if (accept && cnt == LAST_CNT) state_d = S_KICK;
            S_KICK: begin
                start   = 1'b1;
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: if (!done) state_d = S_WAIT_DONE;
            S_WAIT_DONE: if (done) state_d = S_DRAIN;
            S_DRAIN:     if (drain_hs && idx == 3'd7) state_d = S_LOAD;
            default:     state_d = S_LOAD;
        endcase
    end

    // NOTE: the memory array has no reset; clearing it would turn the RAM
    // into thousands of flops. Its contents survive reset by design.
    // Single write port: a host load beats a coincident hasher write.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[load_addr] <= ld_data;
        end else if (mem_we && addr_ok) begin
            mem[mem_addr[AW-1:0]] <= mem_write_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so reads of
    // mem here see the pre-write value (read-during-write returns old data).
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_LOAD;
            ld_ready      <= 1'b0;
            cnt           <= '0;
            idx           <= '0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_last      <= 1'b0;
            hash_count    <= '0;
            err           <= '0;
            mem_read_data <= '0;
        end else begin
            state_q       <= state_d;
            ld_ready      <= (state_d == S_LOAD);
            mem_read_data <= addr_ok ? mem[mem_addr[AW-1:0]] : 32'd0;

            if (!addr_ok)         err[1] <= 1'b1;
            if (accept && mem_we) err[0] <= 1'b1;

            if (accept) begin
                // Sequencing is by count; ld_last is only cross-checked.
                if (ld_last != (cnt == LAST_CNT)) err[2] <= 1'b1;
                cnt <= (cnt == LAST_CNT) ? '0 : cnt + CW'(1);
            end

            if (state_q == S_WAIT_DONE) idx <= '0;

            if (drain_fetch) begin
                out_data  <= mem[drain_addr];
                out_valid <= 1'b1;
                out_last  <= (fetch_idx == 3'd7);
                idx       <= fetch_idx;
            end else if (drain_hs) begin
                out_valid  <= 1'b0;
                out_last   <= 1'b0;
                hash_count <= hash_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_sha256_host_mem.sv
module tb_sha256_host_mem;
    localparam int NW       = 20;
    localparam int OUT_BASE = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_data;
    logic        ld_last;
    logic        start;
    logic        done;
    logic [15:0] message_addr;
    logic [15:0] output_addr;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;
    logic [15:0] hash_count;
    logic [2:0]  err;

    sha256_host_mem dut (
        .clk            (clk),
        .reset          (reset),
        .ld_valid       (ld_valid),
        .ld_ready       (ld_ready),
        .ld_data        (ld_data),
        .ld_last        (ld_last),
        .start          (start),
        .done           (done),
        .message_addr   (message_addr),
        .output_addr    (output_addr),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_last       (out_last),
        .busy           (busy),
        .hash_count     (hash_count),
        .err            (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: what the host sent and what the hasher wrote.
    logic [31:0] msg [NW];
    logic [31:0] hash_w [8];
    int          exp_count = 0;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic        chk;
        logic [31:0] exp_rd;
    } port_vec_t;

    port_vec_t pv [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_msg(input bit fixed, input bit gaps, input int last_at,
                            input int collide_at, input bit toggle_done);
        int i = 0;
        int guard = 0;
        bit drove;
        bit acc;
        for (int k = 0; k < NW; k++) msg[k] = fixed ? 32'(k + 1) : $urandom();
        while (i < NW && guard < 500) begin
            drove          = !(gaps && $urandom_range(0, 3) == 0);
            ld_valid       = drove;
            ld_data        = msg[i];
            ld_last        = (i == last_at);
            mem_we         = drove && (i == collide_at);
            mem_addr       = 16'd50;
            mem_write_data = 32'hBAD0_BAD0;
            if (toggle_done) done = 1'($urandom_range(0, 1));
            acc = drove && ld_ready;
            step();
            if (acc) i++;
            guard++;
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        mem_we   = 1'b0;
        mem_addr = 16'd0;
        done     = 1'b1;
        check("load_word_count", 32'(i), 32'(NW));
        check("start_after_last_accept", 32'(start), 32'd1);
        check("ld_ready_drops", 32'(ld_ready), 32'd0);
        check("busy_in_kick", 32'(busy), 32'd1);
        step();
        check("start_single_cycle", 32'(start), 32'd0);
    endtask

    task automatic readback_msg();
        for (int k = 0; k < NW; k++) begin
            mem_addr = 16'(k);
            step();
            check($sformatf("msg_readback[%0d]", k), mem_read_data, msg[k]);
        end
        mem_addr = 16'd0;
    endtask

    task automatic hasher_run(input bit fixed, input int delay);
        for (int k = 0; k < 8; k++) hash_w[k] = fixed ? 32'hA0 + 32'(k) : $urandom();
        done = 1'b0;
        step();
        repeat (delay) step();
        for (int k = 0; k < 8; k++) begin
            mem_we         = 1'b1;
            mem_addr       = 16'(OUT_BASE + k);
            mem_write_data = hash_w[k];
            step();
        end
        mem_we   = 1'b0;
        mem_addr = 16'd0;
        done     = 1'b1;
        check("busy_while_hashing", 32'(busy), 32'd1);
        check("no_output_while_hashing", 32'(out_valid), 32'd0);
    endtask

    // mode 0: always ready, 1: alternating 0,1,..., 2: random ready and done noise
    task automatic drain(input int mode);
        int n = 0;
        int guard = 0;
        int valid_cycles = 0;
        bit rdy;
        bit alt = 1'b0;
        while (n < 8 && guard < 300) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = alt;
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            if (out_valid) begin
                if (mode == 2) done = 1'($urandom_range(0, 1));
                valid_cycles++;
                alt = ~alt;
                check($sformatf("out_data[%0d]", n), out_data, hash_w[n]);
                check($sformatf("out_last[%0d]", n), 32'(out_last), 32'(n == 7));
                if (rdy) n++;
            end
            step();
            guard++;
        end
        out_ready = 1'b0;
        done      = 1'b1;
        exp_count++;
        check("drain_handshakes", 32'(n), 32'd8);
        if (mode == 0) check("drain_back_to_back", 32'(valid_cycles), 32'd8);
        check("out_valid_after_last", 32'(out_valid), 32'd0);
        check("hash_count", 32'(hash_count), 32'(exp_count));
        check("busy_after_pass", 32'(busy), 32'd0);
        check("ld_ready_after_pass", 32'(ld_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] old0;

        reset = 1'b1; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
        done = 1'b1; mem_we = 1'b0; mem_addr = '0; mem_write_data = '0;
        out_ready = 1'b0;
        step();
        step();
        check("rst_ld_ready", 32'(ld_ready), 32'd0);
        check("rst_start", 32'(start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_mem_read_data", mem_read_data, 32'd0);
        check("rst_hash_count", 32'(hash_count), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("message_addr", 32'(message_addr), 32'd0);
        check("output_addr", 32'(output_addr), 32'(OUT_BASE));
        reset = 1'b0;
        step();
        check("ld_ready_after_reset", 32'(ld_ready), 32'd1);

        // Pass 1: fixed message, hasher port vectors, fixed hash, always ready.
        load_msg(1'b1, 1'b0, NW - 1, -1, 1'b0);
        readback_msg();
        pv[0] = '{1'b0, 16'd5,  32'd0,         1'b1, 32'h0000_0006};
        pv[1] = '{1'b0, 16'd19, 32'd0,         1'b1, 32'h0000_0014};
        pv[2] = '{1'b1, 16'd32, 32'h1111_1111, 1'b0, 32'd0};
        pv[3] = '{1'b1, 16'd32, 32'hDEAD_BEEF, 1'b1, 32'h1111_1111};
        pv[4] = '{1'b0, 16'd32, 32'd0,         1'b1, 32'hDEAD_BEEF};
        pv[5] = '{1'b1, 16'd33, 32'h1234_5678, 1'b0, 32'd0};
        pv[6] = '{1'b0, 16'd33, 32'd0,         1'b1, 32'h1234_5678};
        pv[7] = '{1'b0, 16'd0,  32'd0,         1'b1, 32'h0000_0001};
        for (int k = 0; k < 8; k++) begin
            mem_we         = pv[k].we;
            mem_addr       = pv[k].addr;
            mem_write_data = pv[k].wdata;
            step();
            if (pv[k].chk) check($sformatf("port_vec[%0d]", k), mem_read_data, pv[k].exp_rd);
        end
        mem_we = 1'b0;
        mem_addr = 16'd0;
        check("err_clean_pass1", 32'(err), 32'd0);
        hasher_run(1'b1, 100);
        drain(0);

        // Pass 2: random message with gaps, alternating backpressure.
        load_msg(1'b0, 1'b1, NW - 1, -1, 1'b0);
        readback_msg();
        hasher_run(1'b0, 5);
        drain(1);

        // Error flags.
        old0     = msg[0];
        mem_addr = 16'd0;
        step();
        check("pre_oor_read0", mem_read_data, old0);
        mem_we = 1'b1; mem_addr = 16'd50; mem_write_data = 32'h5050_5050;
        step();
        check("err_before_oor", 32'(err), 32'd0);
        mem_we = 1'b1; mem_addr = 16'h0040; mem_write_data = 32'hFFFF_FFFF;
        step();
        check("oor_read_zero", mem_read_data, 32'd0);
        check("err_oor", 32'(err), 32'b010);
        mem_we = 1'b0; mem_addr = 16'd0;
        step();
        check("oor_write_dropped", mem_read_data, old0);
        check("err_sticky", 32'(err), 32'b010);
        load_msg(1'b0, 1'b1, 9, 3, 1'b0);
        check("err_all", 32'(err), 32'b111);
        readback_msg();
        mem_addr = 16'd50;
        step();
        check("collision_hasher_dropped", mem_read_data, 32'h5050_5050);
        mem_addr = 16'd0;

        // Reset while waiting for done.
        done = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_start", 32'(start), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_ld_ready", 32'(ld_ready), 32'd0);
        check("midrst_hash_count", 32'(hash_count), 32'd0);
        check("midrst_err", 32'(err), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        exp_count = 0;
        done = 1'b1;
        step();
        check("midrst_ld_ready_rise", 32'(ld_ready), 32'd1);
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("midrst_no_stream[%0d]", k), 32'(out_valid), 32'd0);
        end

        // Randomized passes with done noise during LOAD and DRAIN.
        for (int p = 0; p < 3; p++) begin
            load_msg(1'b0, 1'b1, NW - 1, -1, 1'b1);
            readback_msg();
            hasher_run(1'b0, int'($urandom_range(0, 20)));
            drain(2);
        end
        check("err_clean_random", 32'(err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
